// File: rtl/dmux_4_way.sv
// dmux_4_way: 1-to-4 demultiplexer with a combinational path, a one-cycle
// registered copy of that path, and per-channel saturating activity counters.
module dmux_4_way #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] d_q,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_a, w_b, w_c, w_d;
  logic [3:0]       w_hit;

  logic [WIDTH-1:0] r_a_q, r_b_q, r_c_q, r_d_q;
  logic [CNT_W-1:0] r_cnt [4];

  // Route `in` to the selected channel; the three unselected channels are zero.
  always_comb begin
    // NOTE: every output is assigned on every path through this block, so no
    // latch can be inferred; the ternary also lets an X on sel propagate as X.
    w_a = (sel == 2'b00) ? in : '0;
    w_b = (sel == 2'b01) ? in : '0;
    w_c = (sel == 2'b10) ? in : '0;
    w_d = (sel == 2'b11) ? in : '0;
  end

  // A channel is active in a cycle when it carries nonzero data.
  assign w_hit = {|w_d, |w_c, |w_b, |w_a};

  // One-cycle registered copy of the combinational channels.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_a_q <= '0;
      r_b_q <= '0;
      r_c_q <= '0;
      r_d_q <= '0;
    end else begin
      r_a_q <= w_a;
      r_b_q <= w_b;
      r_c_q <= w_c;
      r_d_q <= w_d;
    end
  end

  // Saturating activity counters; only the active channel can advance.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the counter array is small and must read zero straight out of
    // reset, so every entry is cleared explicitly rather than left unreset.
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_hit[i] && (r_cnt[i] != CNT_MAX)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign a     = w_a;
  assign b     = w_b;
  assign c     = w_c;
  assign d     = w_d;
  assign a_q   = r_a_q;
  assign b_q   = r_b_q;
  assign c_q   = r_c_q;
  assign d_q   = r_d_q;
  assign cnt_a = r_cnt[0];
  assign cnt_b = r_cnt[1];
  assign cnt_c = r_cnt[2];
  assign cnt_d = r_cnt[3];

endmodule

// File: tb/tb_dmux_4_way.sv
// tb_dmux_4_way: directed, table-driven bench for dmux_4_way. A second
// instance with a 3-bit counter width exercises counter saturation.
module tb_dmux_4_way;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [1:0] sel;

  logic [3:0] a, b, c, d, a_q, b_q, c_q, d_q;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;

  logic [3:0] s_a, s_b, s_c, s_d, s_a_q, s_b_q, s_c_q, s_d_q;
  logic [2:0] s_cnt_a, s_cnt_b, s_cnt_c, s_cnt_d;

  int errors = 0;
  int checks = 0;

  dmux_4_way #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel),
    .a(a), .b(b), .c(c), .d(d),
    .a_q(a_q), .b_q(b_q), .c_q(c_q), .d_q(d_q),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
  );

  dmux_4_way #(.WIDTH(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .in(in), .sel(sel),
    .a(s_a), .b(s_b), .c(s_c), .d(s_d),
    .a_q(s_a_q), .b_q(s_b_q), .c_q(s_c_q), .d_q(s_d_q),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b), .cnt_c(s_cnt_c), .cnt_d(s_cnt_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] in;
    logic [1:0] sel;
    logic [3:0] a, b, c, d;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string tag, input logic [3:0] ea, eb, ec, ed);
    check({tag, " a"}, {28'd0, a}, {28'd0, ea});
    check({tag, " b"}, {28'd0, b}, {28'd0, eb});
    check({tag, " c"}, {28'd0, c}, {28'd0, ec});
    check({tag, " d"}, {28'd0, d}, {28'd0, ed});
  endtask

  task automatic check_regs(input string tag, input logic [3:0] ea, eb, ec, ed);
    check({tag, " a_q"}, {28'd0, a_q}, {28'd0, ea});
    check({tag, " b_q"}, {28'd0, b_q}, {28'd0, eb});
    check({tag, " c_q"}, {28'd0, c_q}, {28'd0, ec});
    check({tag, " d_q"}, {28'd0, d_q}, {28'd0, ed});
  endtask

  task automatic check_cnts(input string tag, input logic [7:0] ea, eb, ec, ed);
    check({tag, " cnt_a"}, {24'd0, cnt_a}, {24'd0, ea});
    check({tag, " cnt_b"}, {24'd0, cnt_b}, {24'd0, eb});
    check({tag, " cnt_c"}, {24'd0, cnt_c}, {24'd0, ec});
    check({tag, " cnt_d"}, {24'd0, cnt_d}, {24'd0, ed});
  endtask

  task automatic check_sat(input string tag, input logic [2:0] ea, eb, ec, ed);
    check({tag, " s_cnt_a"}, {29'd0, s_cnt_a}, {29'd0, ea});
    check({tag, " s_cnt_b"}, {29'd0, s_cnt_b}, {29'd0, eb});
    check({tag, " s_cnt_c"}, {29'd0, s_cnt_c}, {29'd0, ec});
    check({tag, " s_cnt_d"}, {29'd0, s_cnt_d}, {29'd0, ed});
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            in     sel    a      b      c      d
    vecs[0]  = '{4'h1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{4'h1, 2'b01, 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[2]  = '{4'h1, 2'b10, 4'h0, 4'h0, 4'h1, 4'h0};
    vecs[3]  = '{4'h1, 2'b11, 4'h0, 4'h0, 4'h0, 4'h1};
    vecs[4]  = '{4'h0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[5]  = '{4'h0, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[6]  = '{4'h0, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{4'h0, 2'b11, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{4'hA, 2'b00, 4'hA, 4'h0, 4'h0, 4'h0};
    vecs[9]  = '{4'h5, 2'b01, 4'h0, 4'h5, 4'h0, 4'h0};
    vecs[10] = '{4'hF, 2'b10, 4'h0, 4'h0, 4'hF, 4'h0};
    vecs[11] = '{4'h8, 2'b11, 4'h0, 4'h0, 4'h0, 4'h8};

    rst = 1'b1;
    in  = 4'h0;
    sel = 2'b00;
    #3;
    check_regs("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    check_cnts("reset", 8'd0, 8'd0, 8'd0, 8'd0);
    check_sat("reset", 3'd0, 3'd0, 3'd0, 3'd0);

    // Combinational path, no clock edge needed; reset is held, so the
    // registered side must stay zero while the outputs follow in/sel.
    for (int i = 0; i < 12; i++) begin
      in  = vecs[i].in;
      sel = vecs[i].sel;
      #1;
      check_comb($sformatf("comb[%0d]", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
    end
    check_regs("comb under reset", 4'h0, 4'h0, 4'h0, 4'h0);

    // Release reset with in=0, then sweep sel across edges: nothing counts.
    @(negedge clk);
    in  = 4'h0;
    sel = 2'b00;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel = 2'(s);
      tick();
      check_cnts($sformatf("zero sweep[%0d]", s), 8'd0, 8'd0, 8'd0, 8'd0);
      check_regs($sformatf("zero sweep[%0d]", s), 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Registered path: c_q rises only after the capturing edge.
    @(negedge clk);
    in  = 4'h1;
    sel = 2'b10;
    #1;
    check_regs("reg before edge N", 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    check_regs("reg after edge N", 4'h0, 4'h0, 4'h1, 4'h0);
    @(negedge clk);
    in  = 4'hA;
    sel = 2'b01;
    #1;
    check_regs("reg sel change pending", 4'h0, 4'h0, 4'h1, 4'h0);
    tick();
    check_regs("reg after sel=01", 4'h0, 4'hA, 4'h0, 4'h0);
    check_cnts("cnt after reg seq", 8'd0, 8'd1, 8'd1, 8'd0);

    // Asynchronous reset between edges clears registers and counts at once.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_regs("async rst regs", 4'h0, 4'h0, 4'h0, 4'h0);
    check_cnts("async rst cnts", 8'd0, 8'd0, 8'd0, 8'd0);
    check_comb("comb during rst sel=01", 4'h0, 4'hA, 4'h0, 4'h0);
    sel = 2'b10;
    #1;
    check_comb("comb during rst sel=10", 4'h0, 4'h0, 4'hA, 4'h0);
    tick();
    check_cnts("cnt held in rst", 8'd0, 8'd0, 8'd0, 8'd0);

    // Counters: hold in=1, sel=11 and count edges; the 3-bit copy saturates.
    @(negedge clk);
    in  = 4'h1;
    sel = 2'b11;
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check({$sformatf("cnt_d edge %0d", k)}, {24'd0, cnt_d}, k);
      check({$sformatf("s_cnt_d edge %0d", k)}, {29'd0, s_cnt_d}, (k > 7) ? 7 : k);
      if (k == 5) begin
        check_cnts("cnt after 5", 8'd0, 8'd0, 8'd0, 8'd5);
        check_sat("sat after 5", 3'd0, 3'd0, 3'd0, 3'd5);
      end
    end
    check_sat("sat after 10", 3'd0, 3'd0, 3'd0, 3'd7);
    check_regs("reg while counting", 4'h0, 4'h0, 4'h0, 4'h1);

    // Drive the 8-bit counter past its ceiling; it must stick at 255.
    repeat (250) tick();
    check_cnts("cnt after 260", 8'd0, 8'd0, 8'd0, 8'd255);
    tick();
    check_cnts("cnt after 261", 8'd0, 8'd0, 8'd0, 8'd255);

    // Zero data on another channel leaves every counter unchanged.
    @(negedge clk);
    in  = 4'h0;
    sel = 2'b00;
    repeat (3) tick();
    check_cnts("cnt hold in=0", 8'd0, 8'd0, 8'd0, 8'd255);
    check_sat("sat hold in=0", 3'd0, 3'd0, 3'd0, 3'd7);
    check_regs("reg in=0", 4'h0, 4'h0, 4'h0, 4'h0);

    // A single count on channel a after all that.
    @(negedge clk);
    in = 4'h3;
    tick();
    check_cnts("cnt a single", 8'd1, 8'd0, 8'd0, 8'd255);
    check_regs("reg a single", 4'h3, 4'h0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmux_4_way.md
Name: dmux_4_way

Overview:
- 1-to-4 demultiplexer. Routes data input `in` to one of four outputs selected by `sel`; the other three outputs are driven to zero.
- Provides combinational outputs (gate-level building block, nand2tetris-style chip library) and a one-cycle registered copy for pipelined consumers.
- Per-channel saturating activity counters support debug and coverage.

Parameters:
- WIDTH, 1, data width of `in` and of each routed output.
- CNT_W, 8, width of each per-channel activity counter.

Ports:
- clk  input  1  system clock; all registers rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  data to route.
- sel  input  2  channel select: 00->a, 01->b, 10->c, 11->d.
- a  output  WIDTH  combinational channel 0.
- b  output  WIDTH  combinational channel 1.
- c  output  WIDTH  combinational channel 2.
- d  output  WIDTH  combinational channel 3.
- a_q  output  WIDTH  registered channel 0.
- b_q  output  WIDTH  registered channel 1.
- c_q  output  WIDTH  registered channel 2.
- d_q  output  WIDTH  registered channel 3.
- cnt_a  output  CNT_W  cycles in which channel 0 carried nonzero data.
- cnt_b  output  CNT_W  same for channel 1.
- cnt_c  output  CNT_W  same for channel 2.
- cnt_d  output  CNT_W  same for channel 3.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).
- Combinational path, zero latency, independent of clk/rst:
  - a = (sel==00) ? in : 0
  - b = (sel==01) ? in : 0
  - c = (sel==10) ? in : 0
  - d = (sel==11) ? in : 0
- Unselected outputs are always all-zero. At most one output is nonzero at any time.
- With in=0, all four outputs are 0 regardless of sel.
- Outputs settle within the same delta/timestep as any change on `in` or `sel`; no glitch requirements beyond standard combinational logic.
- sel containing X/Z: outputs are X in simulation. Synthesis is don't-care.
- Registered path: on each rising clk edge, {a_q,b_q,c_q,d_q} <= {a,b,c,d}. Latency is exactly 1 cycle. Registered outputs hold the same one-hot/zero property as the combinational path.
- Counters: on each rising edge, the counter of the selected channel increments by 1 if in != 0. All other counters hold.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Exactly one counter at most changes per cycle.
- Reset: while rst=1 (asserted asynchronously, immediately on assertion):
  - a_q..d_q = 0 and cnt_a..cnt_d = 0.
  - Combinational outputs a..d continue to follow in/sel.
  - Deassertion takes effect at the next rising edge; the first capture occurs on the first edge with rst=0.
- Reset mid-operation discards any pending registered value and all counts. No other state exists.

Test Plan:
- in=1, sel=00 -> (a,b,c,d)=(1,0,0,0); sel=01 -> (0,1,0,0); sel=10 -> (0,0,1,0); sel=11 -> (0,0,0,1); check 1 time unit after each sel change, no clock needed.
- in=0, sweep sel 00..11 -> all of a,b,c,d = 0 at every step; counters unchanged across clock edges.
- Registered path: rst pulse, then in=1, sel=10 at edge N -> c_q=1 and a_q=b_q=d_q=0 after edge N, not before; change to sel=01 -> b_q=1 one edge later.
- Counters: hold in=1, sel=11 for 5 edges -> cnt_d=5, others 0. With CNT_W=3, hold for 10 edges -> cnt_d=7 (saturated).
- Async reset mid-run: counters nonzero, assert rst between edges -> registered outputs and counters go to 0 immediately without a clock edge; a..d still track in/sel during reset.
